syndrome_stream_driver: RTL and testbench

Host-side counterpart of the decoder's byte-stream interface. It accepts one full syndrome block (all rounds) as a parallel word and serialises it into framed bytes on the decoder input channel. It then collects a fixed-length result message from the decoder output channel and presents it as a parallel word, together with a measured decode latency. It is used in FPGA test harnesses and in the multi-FPGA host bridge.

---
 rtl/syndrome_stream_driver.sv | 176 +++++++++++++++++
 tb/tb_syndrome_stream_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_stream_driver.sv
//------------------------------------------------------------------------------
// Module      : syndrome_stream_driver
// Description : Host-side driver for the decoder byte stream. Serialises one
//               syndrome block into a framed byte stream (START_CMD header
//               followed by zero-padded per-round bytes), then collects a
//               fixed-length response and measures the decode latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module syndrome_stream_driver #(
  parameter int         GRID_WIDTH_X = 4,
  parameter int         GRID_WIDTH_Z = 1,
  parameter int         GRID_WIDTH_U = 5,
  parameter logic [7:0] START_CMD    = 8'h01,
  parameter int         RESULT_BYTES = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] i_syndrome_in,
  input  logic                                          i_syndrome_valid,
  output logic                                          o_syndrome_ready,
  output logic [7:0]                                    o_tx_data,
  output logic                                          o_tx_valid,
  input  logic                                          i_tx_ready,
  input  logic [7:0]                                    i_rx_data,
  input  logic                                          i_rx_valid,
  output logic                                          o_rx_ready,
  output logic [8*RESULT_BYTES-1:0]                     o_result_out,
  output logic [15:0]                                   o_latency_out,
  output logic                                          o_result_valid,
  input  logic                                          i_result_ready
);

  localparam int PPR         = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int PU_COUNT    = PPR * GRID_WIDTH_U;
  localparam int BPR         = (PPR + 7) / 8;
  localparam int TOTAL_BYTES = GRID_WIDTH_U * BPR;
  localparam int BCW         = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam int RCW         = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SEND_HDR    = 3'd1;
  localparam logic [2:0] S_SEND_BODY   = 3'd2;
  localparam logic [2:0] S_WAIT_RESULT = 3'd3;
  localparam logic [2:0] S_DONE        = 3'd4;

  logic [2:0]                r_state;
  logic [2:0]                w_state_next;
  logic [PU_COUNT-1:0]       r_syn;
  logic [BCW-1:0]            r_byte_cnt;
  logic [RCW-1:0]            r_rx_cnt;
  logic [15:0]               r_lat_cnt;
  logic [8*RESULT_BYTES-1:0] r_result;
  logic [15:0]               r_latency;
  logic [8*TOTAL_BYTES-1:0]  w_body_flat;
  logic                      w_last_byte;
  logic                      w_last_rx;

  // Body bytes laid out flat: byte r*BPR+k carries PUs 8k..8k+7 of round r;
  // bit positions beyond the round's PU count are padded with zero.
  genvar gr, gk, gi;
  generate
    for (gr = 0; gr < GRID_WIDTH_U; gr++) begin : g_round
      for (gk = 0; gk < BPR; gk++) begin : g_byte
        for (gi = 0; gi < 8; gi++) begin : g_bit
          if (8*gk + gi < PPR) begin : g_data
            assign w_body_flat[8*(gr*BPR+gk)+gi] = r_syn[gr*PPR+8*gk+gi];
          end else begin : g_pad
            assign w_body_flat[8*(gr*BPR+gk)+gi] = 1'b0;
          end
        end
      end
    end
  endgenerate

  assign w_last_byte = (r_byte_cnt == BCW'(TOTAL_BYTES-1));
  assign w_last_rx   = (r_rx_cnt == RCW'(RESULT_BYTES-1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: every transition is gated by its channel handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:        if (i_syndrome_valid)             w_state_next = S_SEND_HDR;
      S_SEND_HDR:    if (i_tx_ready)                   w_state_next = S_SEND_BODY;
      S_SEND_BODY:   if (i_tx_ready && w_last_byte)    w_state_next = S_WAIT_RESULT;
      S_WAIT_RESULT: if (i_rx_valid && w_last_rx)      w_state_next = S_DONE;
      S_DONE:        if (i_result_ready)               w_state_next = S_IDLE;
      default:                                         w_state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    o_syndrome_ready = 1'b0;
    o_tx_valid       = 1'b0;
    o_tx_data        = 8'h00;
    o_rx_ready       = 1'b0;
    o_result_valid   = 1'b0;
    case (r_state)
      S_IDLE:        o_syndrome_ready = 1'b1;
      S_SEND_HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = START_CMD;
      end
      S_SEND_BODY: begin
        o_tx_valid = 1'b1;
        o_tx_data  = w_body_flat[{r_byte_cnt, 3'b000} +: 8];
      end
      S_WAIT_RESULT: o_rx_ready     = 1'b1;
      S_DONE:        o_result_valid = 1'b1;
      default:       o_syndrome_ready = 1'b0;
    endcase
  end

  // Datapath: syndrome capture, byte/rx counters, latency and result assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_syn      <= '0;
      r_byte_cnt <= '0;
      r_rx_cnt   <= '0;
      r_lat_cnt  <= '0;
      r_result   <= '0;
      r_latency  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_syndrome_valid) r_syn <= i_syndrome_in;
        end
        S_SEND_HDR: begin
          if (i_tx_ready) r_byte_cnt <= '0;
        end
        S_SEND_BODY: begin
          if (i_tx_ready) begin
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_lat_cnt  <= '0;
              r_rx_cnt   <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_WAIT_RESULT: begin
          // Latency counts only while the first response byte is outstanding
          if (r_rx_cnt == '0 && !i_rx_valid && r_lat_cnt != 16'hFFFF)
            r_lat_cnt <= r_lat_cnt + 16'd1;
          if (i_rx_valid) begin
            r_result[{r_rx_cnt, 3'b000} +: 8] <= i_rx_data;
            if (w_last_rx) begin
              r_rx_cnt  <= '0;
              r_latency <= r_lat_cnt;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_syn <= r_syn;
        end
      endcase
    end
  end

  assign o_result_out  = r_result;
  assign o_latency_out = r_latency;

endmodule

`default_nettype wire

// File: tb/tb_syndrome_stream_driver.sv
//------------------------------------------------------------------------------
// Module      : tb_syndrome_stream_driver
// Description : Self-checking bench for syndrome_stream_driver. Directed and
//               randomized frames are compared against a behavioural model of
//               the byte framing, response assembly and latency measurement.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_syndrome_stream_driver;

  localparam int PPR = 4;
  localparam int PU  = 20;
  localparam int BPR = 1;
  localparam int TOT = 5;
  localparam int RB  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [PU-1:0] i_syndrome_in;
  logic          i_syndrome_valid;
  logic          o_syndrome_ready;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic [31:0]   o_result_out;
  logic [15:0]   o_latency_out;
  logic          o_result_valid;
  logic          i_result_ready;

  // Second instance with a 5x2 grid over 2 rounds to exercise byte padding
  logic [19:0]   d2_syn;
  logic          d2_syn_valid;
  logic          d2_syn_ready;
  logic [7:0]    d2_tx_data;
  logic          d2_tx_valid;
  logic          d2_tx_ready;
  logic          d2_rx_ready;
  logic [31:0]   d2_result;
  logic [15:0]   d2_latency;
  logic          d2_result_valid;
  logic [7:0]    d2_rx_data = 8'h00;
  logic          d2_rx_valid = 1'b0;
  logic          d2_result_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_result;
  logic [15:0] exp_lat;

  always #5 clk = ~clk;

  syndrome_stream_driver dut (
    .clk              (clk),
    .reset            (reset),
    .i_syndrome_in    (i_syndrome_in),
    .i_syndrome_valid (i_syndrome_valid),
    .o_syndrome_ready (o_syndrome_ready),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready),
    .i_rx_data        (i_rx_data),
    .i_rx_valid       (i_rx_valid),
    .o_rx_ready       (o_rx_ready),
    .o_result_out     (o_result_out),
    .o_latency_out    (o_latency_out),
    .o_result_valid   (o_result_valid),
    .i_result_ready   (i_result_ready)
  );

  syndrome_stream_driver #(
    .GRID_WIDTH_X (5),
    .GRID_WIDTH_Z (2),
    .GRID_WIDTH_U (2)
  ) dut2 (
    .clk              (clk),
    .reset            (reset),
    .i_syndrome_in    (d2_syn),
    .i_syndrome_valid (d2_syn_valid),
    .o_syndrome_ready (d2_syn_ready),
    .o_tx_data        (d2_tx_data),
    .o_tx_valid       (d2_tx_valid),
    .i_tx_ready       (d2_tx_ready),
    .i_rx_data        (d2_rx_data),
    .i_rx_valid       (d2_rx_valid),
    .o_rx_ready       (d2_rx_ready),
    .o_result_out     (d2_result),
    .o_latency_out    (d2_latency),
    .o_result_valid   (d2_result_valid),
    .i_result_ready   (d2_result_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference framing: body byte b is the slice of round b/BPR starting at
  // PU 8*(b%BPR), truncated to the PUs that actually exist in that round.
  function automatic logic [7:0] exp_byte(input logic [PU-1:0] syn, input int b);
    int r, k, nbits;
    logic [63:0] w;
    r = b / BPR;
    k = b % BPR;
    nbits = PPR - 8*k;
    if (nbits > 8) nbits = 8;
    w = 64'(syn) >> (r*PPR + 8*k);
    w = w & ((64'd1 << nbits) - 64'd1);
    return w[7:0];
  endfunction

  task automatic send_frame(input logic [PU-1:0] syn, input bit stall,
                            input bit hold_rx, input logic [7:0] rx0, input int abort_at);
    int idx, cyc;
    bit rdy;
    logic [7:0] expb;
    @(negedge clk);
    check("syn_ready_idle", o_syndrome_ready, 1);
    i_syndrome_in    = syn;
    i_syndrome_valid = 1'b1;
    if (hold_rx) begin
      i_rx_valid = 1'b1;
      i_rx_data  = rx0;
    end
    @(negedge clk);
    i_syndrome_valid = 1'b0;
    i_syndrome_in    = PU'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < TOT + 1 && cyc < 100) begin
      if (abort_at >= 0 && idx == abort_at) return;
      expb = (idx == 0) ? 8'h01 : exp_byte(syn, idx - 1);
      check("tx_valid", o_tx_valid, 1);
      check("tx_data", o_tx_data, expb);
      check("syn_ready_busy", o_syndrome_ready, 0);
      if (hold_rx) check("rx_ready_while_tx", o_rx_ready, 0);
      rdy = stall ? (cyc % 2 == 0) : 1'b1;
      i_tx_ready = rdy;
      if (rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    i_tx_ready = 1'b0;
    check("tx_byte_count", idx, TOT + 1);
    check("tx_cycles", cyc, stall ? 2*TOT + 1 : TOT + 1);
    check("tx_valid_after", o_tx_valid, 0);
    check("rx_ready_wait", o_rx_ready, 1);
  endtask

  task automatic recv(input logic [31:0] bytes, input int delay, input bit gaps);
    int j, cyc;
    bit v;
    j = 0;
    cyc = 0;
    while (j < RB && cyc < delay + 200) begin
      check("rx_ready_wait", o_rx_ready, 1);
      check("result_valid_wait", o_result_valid, 0);
      if (cyc < delay)          v = 1'b0;
      else if (j == 0 || !gaps) v = 1'b1;
      else                      v = 1'($urandom_range(0, 1));
      i_rx_valid = v;
      i_rx_data  = v ? bytes[8*j +: 8] : 8'($urandom);
      if (v) j++;
      @(negedge clk);
      cyc++;
    end
    // Junk traffic while not ready must be ignored
    i_rx_valid = 1'($urandom_range(0, 1));
    i_rx_data  = 8'($urandom);
    check("rx_byte_count", j, RB);
    exp_result = bytes;
    exp_lat    = 16'(delay);
    check("result_valid", o_result_valid, 1);
    check("result_out", o_result_out, exp_result);
    check("latency_out", o_latency_out, exp_lat);
    check("rx_ready_done", o_rx_ready, 0);
  endtask

  task automatic finish_result(input int hold);
    i_result_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("result_valid_hold", o_result_valid, 1);
      check("result_out_hold", o_result_out, exp_result);
      check("latency_hold", o_latency_out, exp_lat);
    end
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;
    i_rx_valid     = 1'b0;
    check("result_valid_clear", o_result_valid, 0);
    check("syn_ready_return", o_syndrome_ready, 1);
  endtask

  initial begin
    logic [PU-1:0] syn;
    logic [31:0]   res;
    logic [7:0]    d2_exp [5];
    int            k;

    reset            = 1'b1;
    i_syndrome_in    = '0;
    i_syndrome_valid = 1'b0;
    i_tx_ready       = 1'b0;
    i_rx_data        = 8'h00;
    i_rx_valid       = 1'b0;
    i_result_ready   = 1'b0;
    d2_syn           = '0;
    d2_syn_valid     = 1'b0;
    d2_tx_ready      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_syn_ready", o_syndrome_ready, 1);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_rx_ready", o_rx_ready, 0);
    check("rst_result_valid", o_result_valid, 0);
    check("rst_result_out", o_result_out, 0);
    check("rst_latency", o_latency_out, 0);
    reset = 1'b0;

    // Directed frame, back-to-back bytes, response after 10 idle cycles
    send_frame(20'hA5F3C, 1'b0, 1'b0, 8'h00, -1);
    recv(32'h44332211, 10, 1'b0);
    finish_result(5);

    // Same frame with alternating tx_ready stalls
    send_frame(20'hA5F3C, 1'b1, 1'b0, 8'h00, -1);
    recv(32'hDEADBEEF, 3, 1'b1);
    finish_result(0);

    // rx_valid held through the send phase: first byte lands immediately
    send_frame(20'h12345, 1'b0, 1'b1, 8'h5A, -1);
    recv(32'hC3A5965A, 0, 1'b0);
    finish_result(1);

    // Reset after the third body byte, then a clean restart
    send_frame(20'h0F0F0, 1'b0, 1'b0, 8'h00, 4);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx_valid", o_tx_valid, 0);
    check("midrst_syn_ready", o_syndrome_ready, 1);
    check("midrst_rx_ready", o_rx_ready, 0);
    check("midrst_result_out", o_result_out, 0);
    check("midrst_latency", o_latency_out, 0);
    reset = 1'b0;
    i_tx_ready = 1'b0;
    send_frame(20'h0F0F0, 1'b0, 1'b0, 8'h00, -1);
    recv(32'h01020304, 7, 1'b1);
    finish_result(2);

    // Randomized frames
    for (int t = 0; t < 6; t++) begin
      syn = PU'($urandom);
      res = $urandom;
      send_frame(syn, 1'($urandom_range(0, 1)), 1'b0, 8'h00, -1);
      recv(res, $urandom_range(0, 15), 1'b1);
      finish_result($urandom_range(0, 3));
    end

    // Padded configuration: 10 PUs per round -> two bytes per round
    d2_exp[0] = 8'h01; d2_exp[1] = 8'hFF; d2_exp[2] = 8'h03;
    d2_exp[3] = 8'hFF; d2_exp[4] = 8'h03;
    @(negedge clk);
    check("d2_syn_ready", d2_syn_ready, 1);
    d2_syn       = 20'hFFFFF;
    d2_syn_valid = 1'b1;
    d2_tx_ready  = 1'b1;
    @(negedge clk);
    d2_syn_valid = 1'b0;
    k = 0;
    while (k < 5) begin
      check("d2_tx_valid", d2_tx_valid, 1);
      check("d2_tx_data", d2_tx_data, d2_exp[k]);
      k++;
      @(negedge clk);
    end
    d2_tx_ready = 1'b0;
    check("d2_tx_valid_after", d2_tx_valid, 0);
    check("d2_rx_ready", d2_rx_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
